if_id_buffer: RTL and testbench

Instruction buffer between the fetch stage and the decode stage of the LoongArch pipeline. Each cycle the fetch stage offers a PC and the instruction word returned by the synchronous instruction SRAM. The buffer stores them in a small circular FIFO and presents them in order to decode through a valid/allowin handshake. It decouples fetch from decode stalls, discards all buffered work on a redirect (branch/exception flush), and flags misaligned PCs as ADEF so decode can raise the exception.

---
 rtl/if_id_buffer.sv | 90 +++++++++
 tb/tb_if_id_buffer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_buffer.sv
`default_nettype none
// ============================================================================
// Module   : if_id_buffer
// Purpose  : Fetch-to-decode instruction buffer. A small circular FIFO of
//            {pc, inst, adef} entries with a valid/allowin handshake on each
//            side, a priority flush, and ADEF tagging of misaligned PCs.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_buffer #(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       fs_valid,
   input  logic [31:0]                fs_pc,
   input  logic [31:0]                fs_inst,
   output logic                       fs_allowin,
   input  logic                       flush,
   input  logic                       ds_allowin,
   output logic                       ds_valid,
   output logic [31:0]                ds_pc,
   output logic [31:0]                ds_inst,
   output logic                       ds_adef,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;

   // Entry storage; pointers wrap naturally because DEPTH is a power of two.
   logic [31:0]        r_pc_mem   [DEPTH];
   logic [31:0]        r_inst_mem [DEPTH];
   logic               r_adef_mem [DEPTH];
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_CNT_W-1:0] r_count;

   logic               w_push;
   logic               w_pop;
   logic               w_full;
   logic               w_empty;

   // Status flags decode registered occupancy only, so neither handshake
   // output has a combinational path from flush or ds_allowin.
   assign w_full     = (r_count == c_CNT_W'(DEPTH));
   assign w_empty    = (r_count == '0);
   assign fs_allowin = ~w_full;
   assign ds_valid   = ~w_empty;
   assign count      = r_count;

   // Flush cancels both sides of the handshake in the same cycle.
   assign w_push = fs_valid & fs_allowin & ~flush;
   assign w_pop  = ds_valid & ds_allowin & ~flush;

   // Head entry is presented directly from storage (no bypass path).
   assign ds_pc   = r_pc_mem[r_rd_ptr];
   assign ds_inst = r_inst_mem[r_rd_ptr];
   assign ds_adef = r_adef_mem[r_rd_ptr];

   // Pointer, occupancy and storage update; flush outranks push and pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_pc_mem[i]   <= '0;
            r_inst_mem[i] <= '0;
            r_adef_mem[i] <= 1'b0;
         end
      end else if (flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= fs_pc;
            r_inst_mem[r_wr_ptr] <= fs_inst;
            r_adef_mem[r_wr_ptr] <= (fs_pc[1:0] != 2'b00);
            r_wr_ptr             <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_if_id_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_buffer
// Purpose  : Scoreboard bench for if_id_buffer (DEPTH = 2). Directed driver
//            pushes expected entries into a queue; a negedge monitor compares
//            the presented head entry against the queue front.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_buffer;

   localparam int c_DEPTH = 2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        adef;
   } entry_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fs_valid = 1'b0;
   logic [31:0] fs_pc = '0;
   logic [31:0] fs_inst = '0;
   logic        fs_allowin;
   logic        flush = 1'b0;
   logic        ds_allowin = 1'b0;
   logic        ds_valid;
   logic [31:0] ds_pc;
   logic [31:0] ds_inst;
   logic        ds_adef;
   logic [1:0]  count;

   entry_t sb[$];
   int     model_count = 0;
   int     checks = 0;
   int     errors = 0;

   if_id_buffer #(.DEPTH(c_DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .fs_valid   (fs_valid),
      .fs_pc      (fs_pc),
      .fs_inst    (fs_inst),
      .fs_allowin (fs_allowin),
      .flush      (flush),
      .ds_allowin (ds_allowin),
      .ds_valid   (ds_valid),
      .ds_pc      (ds_pc),
      .ds_inst    (ds_inst),
      .ds_adef    (ds_adef),
      .count      (count)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Occupancy / flag checks against the bench's own count model.
   task automatic check_state();
      chk("count", 64'(count), 64'(model_count));
      chk("ds_valid", 64'(ds_valid), 64'(model_count != 0));
      chk("fs_allowin", 64'(fs_allowin), 64'(model_count != c_DEPTH));
   endtask

   // One cycle of stimulus: drive, check flags at negedge, update model at posedge.
   task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic da, input logic fl);
      logic acc;
      logic pp;
      fs_valid   = v;
      fs_pc      = pc;
      fs_inst    = inst;
      ds_allowin = da;
      flush      = fl;
      @(negedge clk);
      check_state();
      @(posedge clk);
      acc = v && (model_count != c_DEPTH) && !fl;
      pp  = (model_count != 0) && da && !fl;
      if (fl) begin
         model_count = 0;
         sb.delete();
      end else begin
         if (acc) sb.push_back('{pc: pc, inst: inst, adef: (pc[1:0] != 2'b00)});
         model_count = model_count + int'(acc) - int'(pp);
      end
      #1;
   endtask

   // Monitor: compare presented head with scoreboard front; retire on handshake.
   always @(negedge clk) begin
      if (!reset && ds_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL head_unexpected: got pc %0h expected no entry", ds_pc);
         end else begin
            chk("ds_pc", 64'(ds_pc), 64'(sb[0].pc));
            chk("ds_inst", 64'(ds_inst), 64'(sb[0].inst));
            chk("ds_adef", 64'(ds_adef), 64'(sb[0].adef));
            if (ds_allowin && !flush) void'(sb.pop_front());
         end
      end
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ds_valid", 64'(ds_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_fs_allowin", 64'(fs_allowin), 64'd1);
      chk("rst_ds_pc", 64'(ds_pc), 64'd0);
      chk("rst_ds_inst", 64'(ds_inst), 64'd0);
      chk("rst_ds_adef", 64'(ds_adef), 64'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Stream with decode always ready
      step(1'b1, 32'h1c000000, 32'h02800001, 1'b1, 1'b0);
      step(1'b1, 32'h1c000004, 32'h02800002, 1'b1, 1'b0);
      step(1'b1, 32'h1c000008, 32'h02800003, 1'b1, 1'b0);
      step(1'b0, 32'h0,        32'h0,        1'b1, 1'b0);
      step(1'b0, 32'h0,        32'h0,        1'b1, 1'b0);

      // Fill and backpressure: third offer is refused
      step(1'b1, 32'h1c000000, 32'h11111111, 1'b0, 1'b0);
      step(1'b1, 32'h1c000004, 32'h22222222, 1'b0, 1'b0);
      step(1'b1, 32'h1c000008, 32'h33333333, 1'b0, 1'b0);
      chk("full_count", 64'(count), 64'd2);
      chk("full_allowin", 64'(fs_allowin), 64'd0);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("allowin_after_pop", 64'(fs_allowin), 64'd1);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      // Full with simultaneous pop: only the pop happens
      step(1'b1, 32'h1c000010, 32'h44444444, 1'b0, 1'b0);
      step(1'b1, 32'h1c000014, 32'h55555555, 1'b0, 1'b0);
      step(1'b1, 32'h1c000018, 32'h66666666, 1'b1, 1'b0);
      chk("full_pop_count", 64'(count), 64'd1);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      // Flush with same-cycle push and pop
      step(1'b1, 32'h1c000020, 32'h77777777, 1'b0, 1'b0);
      step(1'b1, 32'h1c000024, 32'h88888888, 1'b0, 1'b0);
      step(1'b1, 32'h1c000100, 32'h99999999, 1'b1, 1'b1);
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_ds_valid", 64'(ds_valid), 64'd0);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Misaligned PC tagged ADEF, following aligned entry is clean
      step(1'b1, 32'h1c000002, 32'h02800000, 1'b0, 1'b0);
      step(1'b1, 32'h1c000004, 32'h02800004, 1'b0, 1'b0);
      chk("adef_set", 64'(ds_adef), 64'd1);
      chk("adef_inst", 64'(ds_inst), 64'h02800000);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("adef_clear", 64'(ds_adef), 64'd0);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Asynchronous reset between edges with one entry buffered
      step(1'b1, 32'h1c000040, 32'habcdef01, 1'b0, 1'b0);
      chk("pre_areset_count", 64'(count), 64'd1);
      fs_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("areset_ds_valid", 64'(ds_valid), 64'd0);
      chk("areset_count", 64'(count), 64'd0);
      chk("areset_ds_pc", 64'(ds_pc), 64'd0);
      chk("areset_ds_inst", 64'(ds_inst), 64'd0);
      chk("areset_fs_allowin", 64'(fs_allowin), 64'd1);
      model_count = 0;
      sb.delete();
      @(posedge clk);
      #1 reset = 1'b0;
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Nothing left over or lost
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
